// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux, fixed-select or round-robin, registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its packet's last beat.
module stream_mux_arb #(
  parameter int N_CH  = 32,
  parameter int WIDTH = 64,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH-1:0]            in_last,
  output logic [N_CH-1:0]            in_ready,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [SEL_W-1:0]           out_ch,
  input  logic                       out_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, nxt_state;
  logic [SEL_W-1:0] lock_ch, nxt_lock, rr_ptr, nxt_rr, rr_start, gnt;
  logic [N_CH-1:0] rot;
  logic has_gnt, adv, xfer;
  int rr_idx;
  assign adv = !out_valid || out_ready;
  assign rr_start = (rr_ptr == SEL_W'(N_CH - 1)) ? '0 : rr_ptr + 1'b1;
  // rot[i] is the valid of channel (rr_start + i) mod N_CH
  assign rot = N_CH'({in_valid, in_valid} >> rr_start);
  always_comb begin
    rr_idx = 0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rot[i]) rr_idx = int'(rr_start) + i;
    if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
  end
  always_comb begin
    gnt = '0;
    has_gnt = 1'b0;
    if (state == LOCKED) begin
      gnt = lock_ch;
      has_gnt = 1'b1;
    end else if (mode) begin
      gnt = SEL_W'(rr_idx);
      has_gnt = |in_valid;
    end else
      for (int i = 0; i < N_CH; i++)
        if (int'(sel) == i) begin
          gnt = SEL_W'(i);
          has_gnt = in_valid[i];
        end
  end
  assign in_ready = (has_gnt && adv && rst_n) ? N_CH'(1) << gnt : '0;
  assign xfer = |(in_ready & in_valid);
  always_comb begin
    nxt_state = state;
    nxt_lock = lock_ch;
    nxt_rr = rr_ptr;
    if (xfer) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (in_last[gnt]) begin
        nxt_state = IDLE;
        nxt_rr = gnt;
      end else if (state == IDLE) begin
        nxt_state = LOCKED;
        nxt_lock = gnt;
      end
`else
      nxt_rr = gnt;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lock_ch <= '0;
      rr_ptr <= SEL_W'(N_CH - 1);
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
    end else begin
      state <= nxt_state;
      lock_ch <= nxt_lock;
      rr_ptr <= nxt_rr;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= in_data[gnt];
        out_last <= in_last[gnt];
        out_ch <= gnt;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed scenarios plus random traffic checked against a rule-level model.
module tb_stream_mux_arb;
  localparam int N = 20, W = 16, SW = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0] in_valid, in_last, in_ready;
  logic mode, out_valid, out_last, out_ready;
  logic [SW-1:0] sel, out_ch;
  logic [W-1:0] out_data;
  int total = 0, bad = 0;
  bit m_lock, m_ov, m_ol;
  int m_lch, m_rr, m_oc;
  logic [W-1:0] m_od;
  int rr_exp[6] = '{0, 3, 19, 0, 3, 19};
`ifdef STREAM_MUX_PKT_LOCK_EN
  int pk_exp[5] = '{2, 2, 2, 2, 1};
`else
  int pk_exp[5] = '{2, 1, 2, 2, 2};
`endif
  stream_mux_arb #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_lock = 0; m_lch = 0; m_rr = N - 1;
    m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
  endtask
  function automatic int grant();
    if (m_lock) return m_lch;
    if (!mode) return (sel < N && in_valid[sel]) ? int'(sel) : -1;
    for (int i = 1; i <= N; i++)
      if (in_valid[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction
  // called just after a falling edge with inputs already driven; returns at the next falling edge
  task automatic step(bit pulse_rst = 0);
    int g;
    bit adv, xfer;
    #1;
    if (pulse_rst) begin
      rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      model_reset();
      rst_n = 1;
      #1;
    end
    g = grant();
    adv = !m_ov || out_ready;
    chk("in_ready", in_ready, (g >= 0 && adv) ? (64'd1 << g) : 64'd0);
    xfer = g >= 0 && adv && in_valid[g];
    if (xfer) begin
      m_od = in_data[g]; m_ol = in_last[g]; m_oc = g; m_ov = 1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (in_last[g]) begin
        m_lock = 0;
        m_rr = g;
      end else if (!m_lock) begin
        m_lock = 1;
        m_lch = g;
      end
`else
      m_rr = g;
`endif
    end else if (out_ready) m_ov = 0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("out_ch", out_ch, m_oc);
    @(negedge clk);
  endtask
  initial begin
    int b1, b2;
    in_data = '0; in_valid = '1; in_last = '0; mode = 1; sel = 0; out_ready = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    rst_n = 1;
    in_valid = N'(1) | (N'(1) << 7);
    in_last = '1;
    step();
    chk("rr_first", out_ch, 0);
    mode = 0; sel = 5; in_valid = N'(1) << 5; in_data[5] = 16'hA5;
    #1 chk("fix_ready", in_ready, 20'h20);
    step();
    chk("fix_data", out_data, 16'hA5);
    chk("fix_ch", out_ch, 5);
    sel = 25; in_valid = '1;
    #1 chk("oor_ready", in_ready, 0);
    step();
    chk("oor_drain", out_valid, 0);
    mode = 1; in_valid = N'(1) | (N'(1) << 3) | (N'(1) << 19);
    foreach (rr_exp[i]) begin
      step(i == 0);
      chk("rr_order", out_ch, rr_exp[i]);
    end
    b1 = 0; b2 = 0;
    foreach (pk_exp[i]) begin
      in_valid = '0; in_last = '0;
      in_valid[2] = b2 < 4; in_last[2] = b2 == 3; in_data[2] = 16'(16'h200 + b2);
      in_valid[1] = i > 0 && b1 < 1; in_last[1] = 1; in_data[1] = 16'h100;
      step(i == 0);
      chk("pkt_order", out_ch, pk_exp[i]);
      if (out_ch == 2) b2++; else b1++;
    end
    mode = 0; sel = 4; in_valid = N'(1) << 4; in_last = '1;
    for (int i = 0; i < 8; i++) begin
      out_ready = !(i inside {[2:4]});
      in_data[4] = 16'(16'h400 + i);
      if (i inside {[3:4]}) #1 chk("bp_ready", in_ready, 0);
      step();
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      sel = SW'($urandom_range(0, 31));
      in_valid = N'($urandom & $urandom);
      in_last = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step($urandom_range(0, 499) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel stream multiplexer with valid/ready handshaking, selectable fixed-select or round-robin arbitration, packet locking, and a registered output stage. It replaces the combinational bus mux wherever a datapath funnels many producers into one consumer, such as register-file write-back or multi-source memory request paths. It adds back-pressure and fairness, and it guarantees that a multi-beat packet is never interleaved with another channel's data.

## Interface
Parameters:
- N_CH, default 32: number of input channels, at least 2.
- WIDTH, default 64: data width in bits.
- SEL_W, default $clog2(N_CH): width of the select and channel-ID fields.

Ports:
- clk, input, 1: rising-edge clock; the block's only clock.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, [N_CH-1:0][WIDTH-1:0]: per-channel data.
- in_valid, input, N_CH: per-channel valid.
- in_last, input, N_CH: per-channel end-of-packet flag.
- in_ready, output, N_CH: per-channel ready; one-hot or zero.
- mode, input, 1: 0 selects fixed-select, 1 selects round-robin.
- sel, input, SEL_W: channel index used in fixed-select mode.
- out_data, output, WIDTH: registered output data.
- out_valid, output, 1: registered output valid.
- out_last, output, 1: registered end-of-packet flag.
- out_ch, output, SEL_W: source channel of the current output beat.
- out_ready, input, 1: consumer ready.

## Operation
- Arbiter state machine with two states.
  - IDLE: no packet is open.
  - LOCKED: a packet is open on channel lock_ch.
- Output stage can accept a beat when `adv = !out_valid || out_ready`.
- Grant in IDLE, fixed-select mode (mode=0):
  - Grant goes to sel if sel < N_CH and in_valid[sel] is high.
  - If sel ≥ N_CH, no grant.
- Grant in IDLE, round-robin mode (mode=1):
  - Grant goes to the first channel with valid high, searching from rr_ptr+1 upward and wrapping modulo N_CH.
- Grant in LOCKED: grant goes to lock_ch only. mode and sel are ignored.
- Ready: in_ready[g] = adv when g is granted; all other in_ready bits are 0.
- Beat transfer: occurs when in_valid[g] && in_ready[g]. The output registers load in_data[g], in_last[g], and g, and out_valid is set to 1.
- State transitions on a transfer:
  - IDLE with in_last=0: go to LOCKED, lock_ch=g.
  - LOCKED with in_last=1: go to IDLE.
- rr_ptr update: set to g on every transfer with in_last=1, in either mode.
- out_valid is cleared when out_ready=1 and no new transfer occurs in that cycle.
- A mode or sel change during LOCKED takes effect only after the packet's last beat.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - State is IDLE and lock_ch=0.
  - rr_ptr=N_CH-1, so channel 0 has the highest priority on the first round-robin grant.
  - in_ready is all 0 while rst_n is low.
- Asserting rst_n mid-packet aborts the packet: the output is cleared immediately and the open packet is not completed.

## Timing
- Latency: input transfer to out_valid is 1 cycle.
- Throughput: one beat per cycle while out_ready stays high.
- When out_ready=0 and out_valid=1:
  - all in_ready bits are 0;
  - out_data, out_last, and out_ch are held stable.
- in_ready is a combinational function of in_valid, mode, sel, state, rr_ptr, out_valid, and out_ready. There is no combinational path from in_data to any output.
- Simultaneous transfer and drain (out_ready=1 and a new beat transfers in the same cycle): the register reloads with no bubble.
- A new grant can be issued in the cycle immediately after a last beat transfers.

## Configuration
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined: packet locking behaves as described in Operation.
- Undefined:
  - The LOCKED state is removed and arbitration is evaluated on every beat.
  - rr_ptr updates on every transfer, regardless of in_last.
  - in_last is still passed through to out_last.

## Test plan
- Reset: hold rst_n=0 with all in_valid high → out_valid=0, in_ready=0, out_ch=0. Release → first round-robin grant goes to channel 0.
- Fixed select: mode=0, sel=5, in_data[5]=64'hA5, in_valid[5]=1 → in_ready=32'h20, and next cycle out_data=64'hA5, out_ch=5.
- Round-robin fairness: mode=1, channels 0, 3, and 31 continuously valid with single-beat packets (last=1) → grant order 0, 3, 31, 0, 3, …
- Packet lock: channel 2 sends a 4-beat packet while channel 1 is valid throughout → output shows four beats from ch2, then ch1; with the macro undefined, ch1 and ch2 beats interleave.
- Back-pressure: out_ready=0 for 3 cycles mid-stream → out_data and out_ch held, in_ready=0. Resume → no beat is lost or duplicated.
- Out-of-range select and reset mid-packet: N_CH=20, sel=25 → no grant. Assert rst_n low mid-packet → out_valid=0 immediately and the next packet starts in IDLE.
